// File: rtl/pingpong_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_bank_buffer
// Purpose  : N-bank ping-pong buffer between the modulation mapper and the
//            FFT. Each bank is FREE or FULL. The writer fills bank wb and
//            commits it with wr_last. The reader drains bank rb and hands it
//            back with rd_release. The mapper and FFT can therefore drift
//            apart by up to NUM_BANKS symbols.
// Ports    : CLK, RST (async, active-high)
//            wr_valid/wr_addr/wr_data/wr_last -> wr_ready   mapper side
//            rd_en/rd_addr/rd_release -> rd_avail/rd_data/rd_valid  FFT side
//            fill_level                number of FULL banks
//            wr_ovf_err/addr_err/err_clr  sticky error flags and their clear
// Options  : PPM_ZERO_FILL_EN - keeps a per-bank written bitmap so that
//            unwritten subcarriers read back as 0.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_bank_buffer #(
  parameter int DATA_WIDTH = 18,
  parameter int MEM_DEPTH  = 1200,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_BANKS  = 2,
  parameter int LVL_WIDTH  = $clog2(NUM_BANKS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [LVL_WIDTH-1:0]  fill_level,
  output logic                  wr_ovf_err,
  output logic                  addr_err,
  input  logic                  err_clr
);

  localparam int c_bank_w = $clog2(NUM_BANKS);
  localparam logic [c_bank_w-1:0] c_last_bank = c_bank_w'(NUM_BANKS - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][MEM_DEPTH];

  logic [c_bank_w-1:0]   r_wb;
  logic [c_bank_w-1:0]   r_rb;
  logic [NUM_BANKS-1:0]  r_state;      // 1 = FULL
  logic [LVL_WIDTH-1:0]  r_fill;
  logic                  r_wr_ovf;
  logic                  r_addr_err;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic w_wr_ready;
  logic w_rd_avail;
  logic w_accept;
  logic w_commit;
  logic w_release;
  logic w_wr_in_range;
  logic w_wr_mem;
  logic w_rd_fire;
  logic w_rd_in_range;
  logic w_rd_written;

  assign w_wr_ready    = ~r_state[r_wb];
  assign w_rd_avail    = r_state[r_rb];
  assign w_accept      = wr_valid & w_wr_ready;
  assign w_commit      = w_accept & wr_last;
  assign w_release     = rd_release & w_rd_avail;
  // Compare at 32 bits so MEM_DEPTH == 2**ADDR_WIDTH does not truncate to 0
  assign w_wr_in_range = (32'(wr_addr) < MEM_DEPTH);
  assign w_rd_in_range = (32'(rd_addr) < MEM_DEPTH);
  assign w_wr_mem      = w_accept & w_wr_in_range;
  assign w_rd_fire     = rd_en & w_rd_avail;

  // Sample storage, deliberately not reset
  always_ff @(posedge CLK) begin
    if (w_wr_mem) begin
      mem[r_wb][wr_addr] <= wr_data;
    end
  end

  // Bank pointers, fill level and sticky errors
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wb       <= '0;
      r_rb       <= '0;
      r_fill     <= '0;
      r_wr_ovf   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wb <= (r_wb == c_last_bank) ? '0 : r_wb + c_bank_w'(1);
      end
      if (w_release) begin
        r_rb <= (r_rb == c_last_bank) ? '0 : r_rb + c_bank_w'(1);
      end
      // A commit needs a FREE bank and a release a FULL one, so when both
      // happen together they touch different banks and the count holds.
      case ({w_commit, w_release})
        2'b10:   r_fill <= r_fill + LVL_WIDTH'(1);
        2'b01:   r_fill <= r_fill - LVL_WIDTH'(1);
        default: r_fill <= r_fill;
      endcase
      // Clear wins over a simultaneous set
      if (err_clr) begin
        r_wr_ovf   <= 1'b0;
        r_addr_err <= 1'b0;
      end else begin
        if (wr_valid && !w_wr_ready) r_wr_ovf   <= 1'b1;
        if (w_accept && !w_wr_in_range) r_addr_err <= 1'b1;
      end
    end
  end

  // Per-bank FREE/FULL state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_commit && (r_wb == c_bank_w'(b))) begin
          r_state[b] <= 1'b1;
        end else if (w_release && (r_rb == c_bank_w'(b))) begin
          r_state[b] <= 1'b0;
        end
      end
    end
  end

`ifdef PPM_ZERO_FILL_EN
  logic [MEM_DEPTH-1:0] r_written [NUM_BANKS];

  // Released banks forget what was written. A release and a write in the
  // same cycle always target different banks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_written[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_release && (r_rb == c_bank_w'(b))) begin
          r_written[b] <= '0;
        end else if (w_wr_mem && (r_wb == c_bank_w'(b))) begin
          r_written[b][wr_addr] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rd_written = 1'b0;
    if (w_rd_in_range) begin
      w_rd_written = r_written[r_rb][rd_addr];
    end
  end
`else
  always_comb begin
    w_rd_written = 1'b1;
  end
`endif

  // Registered read port. Out-of-range or unwritten locations return 0
  // while still flagging valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire && w_rd_in_range && w_rd_written) begin
        r_rd_data <= mem[r_rb][rd_addr];
      end else begin
        r_rd_data <= '0;
      end
    end
  end

  assign wr_ready   = w_wr_ready;
  assign rd_avail   = w_rd_avail;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign fill_level = r_fill;
  assign wr_ovf_err = r_wr_ovf;
  assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: doc/pingpong_bank_buffer.md
# pingpong_bank_buffer

Parametrised N-bank ping-pong buffer between the modulation mapper and the FFT. It generalises the two-bank mapper/FFT buffer to NUM_BANKS banks with per-bank FREE/FULL tracking and explicit commit/release handshakes, so the mapper and FFT can run decoupled by up to NUM_BANKS symbols. Error flags are sticky, and an optional zero-fill mode makes unwritten subcarriers read back as 0.

## Interface
Parameters:
- DATA_WIDTH, 18: sample width (packed I/Q).
- MEM_DEPTH, 1200: entries per bank.
- ADDR_WIDTH, 11: address width; must satisfy 2^ADDR_WIDTH >= MEM_DEPTH.
- NUM_BANKS, 2: bank count, >= 2.
- LVL_WIDTH, clog2(NUM_BANKS+1): fill-level width.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  asynchronous active-high reset.
- wr_valid  in  1  mapper sample strobe.
- wr_addr  in  ADDR_WIDTH  subcarrier address, 0-based.
- wr_data  in  DATA_WIDTH  sample.
- wr_last  in  1  commit current write bank; qualified by wr_valid.
- wr_ready  out  1  current write bank is FREE.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_release  in  1  FFT finished with the current read bank.
- rd_avail  out  1  current read bank is FULL.
- rd_data  out  DATA_WIDTH  read data; 0 when rd_valid=0.
- rd_valid  out  1  rd_data valid.
- fill_level  out  LVL_WIDTH  number of FULL banks.
- wr_ovf_err  out  1  sticky: wr_valid while !wr_ready.
- addr_err  out  1  sticky: accepted write with wr_addr >= MEM_DEPTH.
- err_clr  in  1  clears both sticky errors.

## Operation
- Storage: NUM_BANKS x MEM_DEPTH x DATA_WIDTH. The memory array itself is not reset.
- Each bank holds a 1-bit state, FREE or FULL. There are two pointers: wb (write bank) and rb (read bank). Both advance modulo NUM_BANKS.
- Accept rule: a write is accepted when wr_valid && wr_ready.
  - If wr_addr < MEM_DEPTH, write mem[wb][wr_addr].
  - Otherwise drop the write and set addr_err.
- wr_valid && !wr_ready: sample is dropped, wr_ovf_err is set, and wr_last is ignored.
- Commit: an accepted write with wr_last=1 does its write (if in range), sets state[wb]=FULL, and advances wb.
- Read: when rd_en && rd_avail, rd_data <= mem[rb][rd_addr]. If rd_addr >= MEM_DEPTH, rd_data <= 0 (rd_valid still 1).
- When rd_en && !rd_avail: rd_valid=0 and rd_data=0. No error is raised.
- Release: rd_release && rd_avail sets state[rb]=FREE and advances rb. rd_release while !rd_avail is ignored.
- rd_en and rd_release in the same cycle: the read is served from the bank being released.
- Commit and release in the same cycle always target different banks. Both take effect, and fill_level is unchanged.
- fill_level equals the count of FULL banks, range 0..NUM_BANKS.
- err_clr takes priority over a simultaneous set: the flag reads 0 next cycle.

## Timing
- Reset values: all banks FREE, wb=rb=0, wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0, fill_level=0, both errors 0.
- Reset asserted mid-operation discards all banks immediately, including any FULL bank.
- Write: zero-latency accept; data is stored at the accepting edge.
- Commit to rd_avail: rd_avail rises on the cycle after the commit edge (when rb==committed bank).
- Commit to wr_ready: wr_ready reflects the new wb's state on the cycle after the commit edge.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data. Back-to-back reads give one result per cycle.
- Release to wr_ready: if the writer is blocked on the released bank, wr_ready rises the cycle after the release edge.
- A bank is full for NUM_BANKS committed symbols without a release. wr_ready=0 until the next release.

## Configuration
- PPM_ZERO_FILL_EN defined:
  - Each bank has a MEM_DEPTH-bit written bitmap, cleared at reset and on release of that bank.
  - An accepted in-range write sets the bit.
  - A read of an unset location returns 0 with rd_valid=1.
- PPM_ZERO_FILL_EN undefined:
  - No bitmap is built.
  - Unwritten locations return stale contents, or X after power-up.

## Test plan
- Basic flow: write addr 0..1199 with data=addr+1, wr_last on 1199; read 0..1199 -> rd_avail=1 the cycle after commit, rd_data=addr+1 one cycle after each rd_en, fill_level 1 then 0 after release.
- Backpressure (NUM_BANKS=2): commit two symbols without release -> wr_ready=0, fill_level=2; extra wr_valid sets wr_ovf_err; release -> wr_ready=1 next cycle; err_clr -> wr_ovf_err=0.
- Simultaneous events: commit bank 1 on the same edge as releasing bank 0 -> fill_level stays 1, rb=1, rd_avail=1, wr_ready=1.
- Address error: accepted write at addr 1200 -> addr_err=1, no bank corrupted; rd_addr 1200 -> rd_data=0, rd_valid=1.
- Zero fill (with PPM_ZERO_FILL_EN): write only addr 5=0x155, commit, read 4/5/6 -> 0, 0x155, 0; release, refill bank without addr 5, read 5 -> 0.
- Reset mid-operation: assert RST with 1 bank FULL and a read in flight -> rd_valid=0, rd_data=0, rd_avail=0, fill_level=0, wr_ready=1 immediately.
